// File: rtl/dmem_cache_ctrl.sv
// dmem_cache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// sitting between the CPU load/store port and data_memory.
// One word per line. Read hits return in one cycle. Read misses and all writes
// go to data_memory over its ready/done handshake.
// Optional build macro: CACHE_STATS_EN adds saturating read hit/miss counters
// (hit_count, miss_count). Without it the block has no counters or extra ports.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | cpu_ready=1, accept a request, look up the cache
// RD_REQ   | read miss, wait for mem_ready, then issue the mem_rd_en strobe
// RD_WAIT  | read strobe issued, wait for mem_done, then fill the line
// WR_REQ   | write, wait for mem_ready, then issue the mem_wr_en strobe
// WR_WAIT  | write strobe issued, wait for mem_done
// RESP     | cpu_done pulse, with cpu_rd_data valid for reads
module dmem_cache_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_LINES  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_rd_en,
  input  logic                  cpu_wr_en,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wr_data,
  output logic [DATA_WIDTH-1:0] cpu_rd_data,
  output logic                  cpu_ready,
  output logic                  cpu_done,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_ready,
  input  logic                  mem_done
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] WR_WAIT = 3'd4;
  localparam logic [2:0] RESP    = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d;

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_mem [NUM_LINES];

  logic [IDX_W-1:0]      req_idx, lat_idx, line_idx;
  logic [TAG_W-1:0]      req_tag, lat_tag, line_tag;
  logic [DATA_WIDTH-1:0] line_data;
  logic                  line_we;
  logic                  req_hit;
  logic                  rd_hit, rd_miss;

  assign req_idx = cpu_addr[IDX_W-1:0];
  assign req_tag = cpu_addr[ADDR_WIDTH-1:IDX_W];
  assign lat_idx = addr_q[IDX_W-1:0];
  assign lat_tag = addr_q[ADDR_WIDTH-1:IDX_W];
  assign req_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  assign cpu_ready   = (state_q == IDLE);
  assign cpu_done    = (state_q == RESP);
  assign cpu_rd_data = cpu_done ? rdata_q : '0;
  // Strobes are single-cycle because the state advances on the same edge.
  assign mem_rd_en   = (state_q == RD_REQ) && mem_ready;
  assign mem_wr_en   = (state_q == WR_REQ) && mem_ready;
  assign mem_address = addr_q;
  assign mem_wr_data = wdata_q;

  // Next-state, request latching, line update and fill selection.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    valid_d   = valid_q;
    line_we   = 1'b0;
    line_idx  = req_idx;
    line_tag  = req_tag;
    line_data = cpu_wr_data;
    rd_hit    = 1'b0;
    rd_miss   = 1'b0;
    case (state_q)
      IDLE: begin
        rdata_d = '0;
        if (cpu_rd_en || cpu_wr_en) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wr_data;
          if (cpu_wr_en) begin
            // Write wins over a simultaneous read; hits update in place,
            // misses leave the cache untouched.
            state_d = WR_REQ;
            line_we = req_hit;
          end else if (req_hit) begin
            rd_hit  = 1'b1;
            rdata_d = data_mem[req_idx];
            state_d = RESP;
          end else begin
            rd_miss = 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (mem_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_done) begin
          line_we          = 1'b1;
          line_idx         = lat_idx;
          line_tag         = lat_tag;
          line_data        = mem_rd_data;
          valid_d[lat_idx] = 1'b1;
          rdata_d          = mem_rd_data;
          state_d          = RESP;
        end
      end
      WR_REQ: begin
        if (mem_ready) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (mem_done) begin
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and latched request; reset abandons any transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  end

  // Line storage write port (write hit update or miss fill).
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[line_idx]  <= line_tag;
      data_mem[line_idx] <= line_data;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Saturating read hit/miss counters; writes are not counted.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (rd_hit && (hit_count_q != 32'hFFFF_FFFF))
      hit_count_d = hit_count_q + 32'd1;
    if (rd_miss && (miss_count_q != 32'hFFFF_FFFF))
      miss_count_d = miss_count_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  logic unused_stats;
  assign unused_stats = rd_hit ^ rd_miss;
`endif

endmodule
